// File: rtl/spi_sram_slave_if.sv
// SPI pin bundle plus status strobes for the serial-SRAM responder.
// The slave modport is the responder's view; the master modport is the
// view of whatever drives the SPI pins (bridge or testbench).
interface spi_sram_slave_if;
  logic spi_sck;
  logic spi_ss;
  logic spi_mosi;
  logic spi_miso;
  logic o_busy;
  logic o_wr_strobe;
  logic o_cmd_err;

  modport slave (
    input  spi_sck,
    input  spi_ss,
    input  spi_mosi,
    output spi_miso,
    output o_busy,
    output o_wr_strobe,
    output o_cmd_err
  );

  modport master (
    output spi_sck,
    output spi_ss,
    output spi_mosi,
    input  spi_miso,
    input  o_busy,
    input  o_wr_strobe,
    input  o_cmd_err
  );
endinterface

// File: rtl/spi_sram_slave.sv
// SPI mode-0 responder emulating a 23LC-style serial SRAM.
// Commands: 0x02 WRITE, 0x03 READ, followed by an ADDRESS_WIDTH-bit address
// and a stream of data bytes with sequential auto-increment (wrapping at the
// internal RAM depth). The SPI pins are oversampled by the system clock, so
// every protocol action keys off single-cycle sck edge pulses.
module spi_sram_slave #(
  parameter int MEM_AW        = 10,
  parameter int ADDRESS_WIDTH = 24
) (
  input logic             clock,
  input logic             reset,
  spi_sram_slave_if.slave bus
);

  localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;
  localparam int ABW        = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [ABW-1:0] LAST_ADDR_BYTE = ABW'(ADDR_BYTES - 1);
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_RDATA  = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  // Pin synchronizers; sck gets a third flop for edge detection.
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic ss_meta_q, ss_sync_q;
  logic mosi_meta_q, mosi_sync_q;
  logic sck_rise, sck_fall;

  // Protocol state.
  state_t                   state_q, state_d;
  logic                     is_read_q, is_read_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [ABW-1:0]           addr_byte_q, addr_byte_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               rx_shift_q, rx_shift_d;
  logic [7:0]               tx_shift_q, tx_shift_d;
  logic                     spi_miso_q, spi_miso_d;
  logic                     o_busy_q, o_busy_d;
  logic                     o_wr_strobe_q, o_wr_strobe_d;
  logic                     o_cmd_err_q, o_cmd_err_d;

  // RAM port controls produced by the protocol logic.
  logic              ram_we;
  logic              ram_re;
  logic [MEM_AW-1:0] ram_raddr;
  logic [MEM_AW-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        prefetch_q;
  logic [7:0]        mem [0:(1 << MEM_AW) - 1];

  // Helper values derived from current state.
  logic [7:0]               rx_next;
  logic [ADDRESS_WIDTH-1:0] addr_next;
  logic [MEM_AW-1:0]        addr_inc;
  logic                     addr_msb_unused;

  assign sck_rise        = sck_sync_q & ~sck_prev_q;
  assign sck_fall        = ~sck_sync_q & sck_prev_q;
  assign rx_next         = {rx_shift_q[6:0], mosi_sync_q};
  assign addr_next       = {addr_q[ADDRESS_WIDTH-2:0], mosi_sync_q};
  assign addr_inc        = addr_q[MEM_AW-1:0] + MEM_AW'(1);
  // Only the low MEM_AW address bits select RAM; the top bit only shifts out.
  assign addr_msb_unused = addr_q[ADDRESS_WIDTH-1];

  // Double-flop the asynchronous SPI pins into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sck_meta_q  <= bus.spi_sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      ss_meta_q   <= bus.spi_ss;
      ss_sync_q   <= ss_meta_q;
      mosi_meta_q <= bus.spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // Next-state logic for the command / address / data sequencer.
  always_comb begin
    state_d       = state_q;
    is_read_d     = is_read_q;
    bit_cnt_d     = bit_cnt_q;
    addr_byte_d   = addr_byte_q;
    addr_d        = addr_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_raddr     = addr_q[MEM_AW-1:0];
    ram_waddr     = addr_q[MEM_AW-1:0];
    ram_wdata     = rx_next;
    o_cmd_err_d   = 1'b0;

    if (ss_sync_q) begin
      // Deselect wins over everything, including a coincident sck_rise;
      // any partial byte is simply dropped.
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_CMD;
          bit_cnt_d = 3'd0;
        end

        S_CMD: begin
          if (sck_rise) begin
            rx_shift_d = rx_next;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d      = '0;
              addr_byte_d = '0;
              tx_shift_d  = 8'h00;
              case (rx_next)
                CMD_WRITE: begin
                  state_d   = S_ADDR;
                  is_read_d = 1'b0;
                end
                CMD_READ: begin
                  state_d   = S_ADDR;
                  is_read_d = 1'b1;
                end
                default: begin
                  state_d     = S_IGNORE;
                  o_cmd_err_d = 1'b1;
                end
              endcase
            end
          end
        end

        S_ADDR: begin
          if (sck_rise) begin
            addr_d    = addr_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_byte_d = addr_byte_q + ABW'(1);
              if (addr_byte_q == LAST_ADDR_BYTE) begin
                addr_d = ADDRESS_WIDTH'(addr_next[MEM_AW-1:0]);
                if (is_read_q) begin
                  // Prime the prefetch so the first byte is ready at the next fall.
                  state_d   = S_RDATA;
                  ram_re    = 1'b1;
                  ram_raddr = addr_next[MEM_AW-1:0];
                end else begin
                  state_d = S_WDATA;
                end
              end
            end
          end
        end

        S_WDATA: begin
          if (sck_rise) begin
            rx_shift_d = rx_next;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ram_we = 1'b1;
              addr_d = ADDRESS_WIDTH'(addr_inc);
            end
          end
        end

        S_RDATA: begin
          if (sck_fall) begin
            if (bit_cnt_q == 3'd0) begin
              // Byte boundary: present the prefetched byte and fetch the next one.
              tx_shift_d = prefetch_q;
              addr_d     = ADDRESS_WIDTH'(addr_inc);
              ram_re     = 1'b1;
              ram_raddr  = addr_inc;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end

        S_IGNORE: begin
          state_d = S_IGNORE;
        end

        default: begin
          state_d   = S_IDLE;
          bit_cnt_d = 3'd0;
        end
      endcase
    end

    spi_miso_d    = ((state_d == S_RDATA) && !ss_sync_q) ? tx_shift_d[7] : 1'b0;
    o_busy_d      = (state_d != S_IDLE);
    o_wr_strobe_d = ram_we;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      is_read_q     <= 1'b0;
      bit_cnt_q     <= 3'd0;
      addr_byte_q   <= '0;
      addr_q        <= '0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'h00;
      spi_miso_q    <= 1'b0;
      o_busy_q      <= 1'b0;
      o_wr_strobe_q <= 1'b0;
      o_cmd_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_read_q     <= is_read_d;
      bit_cnt_q     <= bit_cnt_d;
      addr_byte_q   <= addr_byte_d;
      addr_q        <= addr_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      spi_miso_q    <= spi_miso_d;
      o_busy_q      <= o_busy_d;
      o_wr_strobe_q <= o_wr_strobe_d;
      o_cmd_err_q   <= o_cmd_err_d;
    end
  end

  // Byte RAM with a registered read port feeding the prefetch byte; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (ram_re) begin
      prefetch_q <= mem[ram_raddr];
    end
  end

  assign bus.spi_miso    = spi_miso_q;
  assign bus.o_busy      = o_busy_q;
  assign bus.o_wr_strobe = o_wr_strobe_q;
  assign bus.o_cmd_err   = o_cmd_err_q;

endmodule

// File: tb/tb_spi_sram_slave.sv
// Directed testbench for spi_sram_slave: a mode-0 SPI master driving SCK at
// clock/8, a byte-array memory model and a scoreboard queue of expected MISO
// bytes pushed when a READ is issued and popped as bytes come back.
module tb_spi_sram_slave;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  spi_sram_slave_if bus_if ();

  spi_sram_slave #(
    .MEM_AW        (10),
    .ADDRESS_WIDTH (24)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         strobe_cnt = 0;
  int         cmd_err_cnt = 0;
  int         miso_hi_cnt = 0;
  logic [7:0] model_mem [0:1023];
  logic [7:0] exp_q [$];

  // Pulse counters sampled away from the active edge.
  always @(negedge clock) begin
    if (bus_if.o_wr_strobe === 1'b1) strobe_cnt++;
    if (bus_if.o_cmd_err === 1'b1) cmd_err_cnt++;
    if (bus_if.spi_miso === 1'b1) miso_hi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Shift nbits of tx (MSB first); MISO is sampled just before each rising edge.
  task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus_if.spi_mosi = tx[7-i];
      bus_if.spi_sck  = 1'b0;
      wait_clks(4);
      rx[7-i] = bus_if.spi_miso;
      bus_if.spi_sck = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic start_txn();
    bus_if.spi_sck = 1'b0;
    bus_if.spi_ss  = 1'b0;
    wait_clks(4);
  endtask

  // Return SCK low, deselect, and hold ss high for two SCK periods.
  task automatic end_txn();
    bus_if.spi_sck = 1'b0;
    wait_clks(4);
    bus_if.spi_ss = 1'b1;
    wait_clks(16);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    send_bits(cmd, 8, rx);
    send_bits(addr[23:16], 8, rx);
    send_bits(addr[15:8], 8, rx);
    send_bits(addr[7:0], 8, rx);
  endtask

  // WRITE of n bytes taken MSB-first from data; updates the memory model.
  task automatic write_txn(input logic [23:0] addr, input logic [31:0] data, input int n);
    logic [7:0] rx;
    logic [9:0] a;
    logic [7:0] b;
    start_txn();
    send_header(8'h02, addr);
    a = addr[9:0];
    for (int i = 0; i < n; i++) begin
      b = data[31-8*i -: 8];
      send_bits(b, 8, rx);
      model_mem[a] = b;
      a = a + 10'd1;
    end
    end_txn();
  endtask

  // READ of n bytes; expectations go to the scoreboard before clocking data out.
  task automatic read_txn(input string tag, input logic [23:0] addr, input int n);
    logic [7:0] rx;
    logic [7:0] e;
    logic [9:0] a;
    start_txn();
    send_header(8'h03, addr);
    a = addr[9:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[a]);
      a = a + 10'd1;
    end
    check({tag, " busy"}, {31'd0, bus_if.o_busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      send_bits(8'h00, 8, rx);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check(tag, {24'd0, rx}, {24'd0, e});
    end
    end_txn();
  endtask

  initial begin
    int         s0;
    int         e0;
    int         m0;
    logic [7:0] rx;
    logic [31:0] rnd;

    reset           = 1'b1;
    bus_if.spi_sck  = 1'b0;
    bus_if.spi_ss   = 1'b1;
    bus_if.spi_mosi = 1'b0;
    wait_clks(5);
    check("reset miso",   {31'd0, bus_if.spi_miso},    32'd0);
    check("reset busy",   {31'd0, bus_if.o_busy},      32'd0);
    check("reset strobe", {31'd0, bus_if.o_wr_strobe}, 32'd0);
    check("reset cmderr", {31'd0, bus_if.o_cmd_err},   32'd0);
    reset = 1'b0;
    wait_clks(4);

    // Basic write / read-back with four bytes.
    s0 = strobe_cnt;
    write_txn(24'h0082E0, 32'h78563412, 4);
    check("write4 strobes", strobe_cnt - s0, 32'd4);
    read_txn("read 0082E0", 24'h0082E0, 4);

    // Address wrap at the top of a 1 KiB RAM.
    s0 = strobe_cnt;
    write_txn(24'h0003FF, 32'hAABB0000, 2);
    check("wrap strobes", strobe_cnt - s0, 32'd2);
    read_txn("read 0003FF", 24'h0003FF, 2);
    read_txn("read 000000", 24'h000000, 1);

    // Aborted write: a partial second byte must never reach RAM.
    write_txn(24'h000010, 32'h11C30000, 2);
    s0 = strobe_cnt;
    start_txn();
    send_header(8'h02, 24'h000010);
    send_bits(8'h5A, 8, rx);
    model_mem[10'h010] = 8'h5A;
    send_bits(8'hFF, 5, rx);
    end_txn();
    check("abort strobes", strobe_cnt - s0, 32'd1);
    read_txn("read abort", 24'h000010, 2);

    // Unsupported command: one error pulse, silent MISO, busy drops 3 clocks after ss.
    s0 = strobe_cnt;
    e0 = cmd_err_cnt;
    m0 = miso_hi_cnt;
    start_txn();
    send_header(8'h9F, 24'hFFFFFF);
    bus_if.spi_sck = 1'b0;
    wait_clks(4);
    bus_if.spi_ss = 1'b1;
    wait_clks(2);
    check("badcmd busy@2", {31'd0, bus_if.o_busy}, 32'd1);
    wait_clks(1);
    check("badcmd busy@3", {31'd0, bus_if.o_busy}, 32'd0);
    wait_clks(14);
    check("badcmd errpulses", cmd_err_cnt - e0, 32'd1);
    check("badcmd miso", miso_hi_cnt - m0, 32'd0);
    check("badcmd strobes", strobe_cnt - s0, 32'd0);

    // Async reset in the middle of a READ data byte (0x78 = 0111_1000).
    start_txn();
    send_header(8'h03, 24'h0082E0);
    send_bits(8'h00, 3, rx);
    check("rst 3bits", {24'd0, rx}, 32'h60);
    bus_if.spi_sck = 1'b0;
    wait_clks(4);
    check("rst pre miso", {31'd0, bus_if.spi_miso}, 32'd1);
    check("rst pre busy", {31'd0, bus_if.o_busy}, 32'd1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("rst async miso", {31'd0, bus_if.spi_miso}, 32'd0);
    check("rst async busy", {31'd0, bus_if.o_busy}, 32'd0);
    bus_if.spi_ss = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(4);
    read_txn("read after rst", 24'h0082E0, 4);

    // Back-to-back transactions with minimum deselect time.
    rnd = $urandom();
    write_txn(24'h000155, 32'hC0FFEE01, 4);
    read_txn("b2b read 155", 24'h000155, 4);
    read_txn("b2b read 157", 24'h000157, 2);
    write_txn(24'h000200, rnd, 4);
    read_txn("b2b read rnd", 24'h000200, 4);

    check("scoreboard empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_sram_slave.md
Name: spi_sram_slave

Overview:
SPI mode-0 responder that emulates a 23LC-style serial SRAM: READ (0x03) and WRITE (0x02) commands, 24-bit address, sequential byte auto-increment. It is the far end of the SPI master bridge, lets the Wishbone-to-SPI path be exercised on-chip and in simulation without an external memory part, and is backed by an internal synchronous byte RAM. The SPI pins are oversampled by the system clock.

Parameters:
MEM_AW, 10, byte-address width of internal RAM (depth 2^MEM_AW bytes); incoming 24-bit address uses low MEM_AW bits
ADDRESS_WIDTH, 24, address bits shifted in after the command byte (must be a multiple of 8)

Ports:
clock  in  1  system clock; must be ≥8× SCK frequency
reset  in  1  asynchronous active-high reset
spi_sck  in  1  SPI clock from master, idle low
spi_ss  in  1  slave select, active low
spi_mosi  in  1  master-out data, MSB first
spi_miso  out  1  slave-out data, MSB first
o_busy  out  1  high while a transaction is in progress (state != IDLE)
o_wr_strobe  out  1  one-cycle pulse per byte committed to RAM
o_cmd_err  out  1  one-cycle pulse when an unsupported command byte completes

Behaviour:
- Input conditioning: sck, ss, mosi each pass through a 2-flop synchronizer; sck_rise/sck_fall come from a third flop; these are single-cycle pulses. All protocol actions key off these pulses only; clock is the sole clock.
- Reset (async assert, sync use): state IDLE, bit_cnt 0, addr 0, shift regs 0, spi_miso 0, o_busy 0, o_wr_strobe 0, o_cmd_err 0. RAM contents are not cleared.
- ss_sync high in any state -> next cycle state IDLE, bit_cnt 0; a partial byte is discarded (never written); spi_miso 0.
- States:
  IDLE: when ss_sync low -> CMD, bit_cnt 0.
  CMD: shift mosi on sck_rise; after 8th bit: 0x02 -> ADDR(write), 0x03 -> ADDR(read), other -> IGNORE and pulse o_cmd_err.
  ADDR: shift ADDRESS_WIDTH bits on sck_rise; on last bit, latch addr = low MEM_AW bits, go WDATA or RDATA; on RDATA entry issue RAM read of addr into prefetch (1-cycle RAM latency).
  WDATA: shift 8 bits on sck_rise; on 8th bit write byte to mem[addr], pulse o_wr_strobe, addr <= addr+1 mod 2^MEM_AW, bit_cnt 0; repeat until ss high.
  RDATA: on sck_fall with bit_cnt==0: tx_shift <= prefetch, addr <= addr+1 (wrap), re-read prefetch from new addr; other sck_fall: tx_shift <<= 1. bit_cnt counts sck_rise modulo 8.
  IGNORE: no shifting, no writes, spi_miso 0 until ss high.
- spi_miso = tx_shift[7] in RDATA with ss_sync low, else 0 (registered). It updates 3 clock cycles after the pin-level SCK fall, well before the next rise under the 8× rule.
- bit_cnt is 3 bits; the address counter is 24 bits and is reset to 0 on entry to ADDR.
- Write and read of the same address within one transaction cannot occur (a transaction is single-direction).
- sck_rise and ss deassertion in the same cycle: ss wins, and the bit is dropped.
- Reset mid-transaction: immediate return to reset values; the master must reassert ss to start again.

Test Plan:
- WRITE 02 0082E0 data 78 56 34 12, ss high; READ 03 0082E0 with 4 dummy bytes -> MISO bytes 78 56 34 12; o_wr_strobe pulses exactly 4 times.
- Wrap at MEM_AW=10: WRITE 02 0003FF data AA BB; READ 03 0003FF -> AA BB; READ 03 000000 -> BB.
- Abort: WRITE 02 000010 data 5A, then 5 bits of a 2nd byte, ss high; READ 000010 two bytes -> 5A, then the prior content of 0x11 (unchanged); only 1 strobe.
- Bad command 9F followed by 24 clocks -> o_cmd_err single pulse after 8th bit, MISO 0 throughout, no strobes, o_busy drops 3 cycles after ss high.
- Async reset asserted mid-READ at bit 3 of data -> spi_miso 0 and o_busy 0 without waiting for a clock edge; a fresh READ after release returns correct data.
- Back-to-back transactions with ss high for only 2 SCK periods, using SCK = clock/8 -> all data bits correct, with no bit slip at the 8× boundary.
